// File: rtl/regbank_dump_ctrl.sv
// Streams a register bank out over a byte-wide valid/ready link.
// Registers go out in ascending address order, least-significant byte first.
module regbank_dump_ctrl #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDRESS  = 5,
  parameter int N_REGISTERS = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [NB_ADDRESS-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0]    i_rd_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int N_BYTES = NB_DATA / 8;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(N_BYTES - 1);
  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_REGISTERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NB_ADDRESS-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state logic; outputs are derived from the next state so they leave as flops.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD;
          addr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          shift_d    = i_rd_data;
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Abort beats a same-cycle handshake: the in-flight byte is dropped.
        if (i_abort) begin
          state_d = IDLE;
        end else if (i_tx_ready) begin
          if (byte_cnt_q != LAST_BYTE) begin
            shift_d    = shift_q >> 4'd8;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end else if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + 1'b1;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_valid_d = (state_d == SEND);
    tx_data_d  = tx_valid_d ? shift_d[7:0] : 8'h00;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and registered outputs, cleared asynchronously by i_reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_rd_addr  = addr_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: doc/regbank_dump_ctrl.md
REGBANK_DUMP_CTRL -- requirements
Module: regbank_dump_ctrl

Interface
REQ-001 Parameter NB_DATA, default 32, register word width; SHALL be a multiple of 8.
REQ-002 Parameter NB_ADDRESS, default 5, register bank address width.
REQ-003 Parameter N_REGISTERS, default 32, number of registers dumped; SHALL be 2 to 2**NB_ADDRESS.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  dump request, sampled only in IDLE.
REQ-007 i_abort  in  1  synchronous abort of a dump in progress.
REQ-008 o_rd_addr  out  NB_ADDRESS  address driven to the register bank read port.
REQ-009 i_rd_data  in  NB_DATA  combinational read data returned for o_rd_addr.
REQ-010 o_tx_data  out  8  byte to the debug transmitter.
REQ-011 o_tx_valid  out  1  o_tx_data is valid.
REQ-012 i_tx_ready  in  1  transmitter accepts the byte this cycle.
REQ-013 o_busy  out  1  high in every state except IDLE.
REQ-014 o_done  out  1  one-cycle pulse when a full dump completes.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SEND and DONE, held in a registered state variable.
REQ-016 IDLE: i_start=1 -> LOAD with addr=0; otherwise stay in IDLE.
REQ-017 LOAD (one cycle): capture i_rd_data into a NB_DATA shift register, clear byte_cnt, -> SEND.
REQ-018 SEND: o_tx_valid=1 and o_tx_data=shift[7:0]; while i_tx_ready=0, state, o_tx_data and o_tx_valid SHALL hold.
REQ-019 SEND, handshake (valid&ready) with byte_cnt < NB_DATA/8-1: shift right by 8, byte_cnt+1, stay in SEND.
REQ-020 SEND, handshake on last byte with addr < N_REGISTERS-1: addr+1, -> LOAD.
REQ-021 SEND, handshake on last byte with addr = N_REGISTERS-1: -> DONE; addr SHALL NOT wrap.
REQ-022 Byte order SHALL be least-significant byte first; registers SHALL be sent in ascending address order.
REQ-023 DONE: o_done=1 for exactly one cycle, -> IDLE; o_tx_valid=0.
REQ-024 o_rd_addr SHALL equal the registered addr at all times; o_tx_valid SHALL be 1 only in SEND.
REQ-025 i_start SHALL be ignored in LOAD, SEND and DONE.
REQ-026 i_abort=1 in LOAD or SEND SHALL force IDLE on the next edge; o_done stays 0; an in-flight byte is dropped even if i_tx_ready=1 that cycle.
REQ-027 i_abort and i_start both high in IDLE: i_start wins; i_abort is ignored in IDLE and DONE.
REQ-028 With i_tx_ready held at 1, a dump SHALL take N_REGISTERS*(1+NB_DATA/8) cycles from the first LOAD cycle to the last SEND cycle, followed by one DONE cycle.

Reset
REQ-029 i_reset=1 SHALL immediately, without waiting for a clock edge, force: state IDLE, addr 0, shift register 0, byte_cnt 0, o_tx_valid 0, o_tx_data 0, o_busy 0, o_done 0, o_rd_addr 0.
REQ-030 Reset asserted mid-dump SHALL abandon the dump; after deassertion the block SHALL wait in IDLE for a new i_start.

Verification
REQ-031 Defaults, regs[k]=32'hA0B0C000+k, i_tx_ready=1, i_start pulse at edge 0 -> LOAD in cycle 1; bytes 00,C0,B0,A0,01,C0,B0,A0,...; 128 handshakes; o_done pulse in cycle 161; o_busy 1 in cycles 1-161.
REQ-032 Backpressure: i_tx_ready=0 for 5 cycles during byte 2 of reg 3 -> o_tx_data=8'hB0 and o_tx_valid=1 held stable; no byte lost or duplicated; total sequence unchanged.
REQ-033 i_abort=1 during SEND of reg 7 -> IDLE next edge, o_tx_valid=0, o_done never pulses; a new i_start restarts from o_rd_addr=0.
REQ-034 Asynchronous i_reset between edges during reg 10 -> o_tx_valid, o_busy and o_rd_addr go to 0 before the next edge; after release, no activity until i_start.
REQ-035 i_start pulsed repeatedly mid-dump -> no restart, address sequence stays monotonic, exactly one o_done.
REQ-036 N_REGISTERS=2, NB_DATA=8 -> sequence LOAD,SEND,LOAD,SEND,DONE; exactly 2 bytes sent; o_rd_addr stops at 1 with no wrap.
